// File: rtl/reply_supervisor_if.sv
// Command/reply link bundle between the sequencer/receiver side (master) and the
// per-channel reply supervisor (slave).
interface reply_supervisor_if #(
  parameter int N_CH = 3
);
  logic [N_CH-1:0] delays_after_cmds_for_reply;
  logic            rx_start_bit_accepted;
  logic            rx_frame_end;
  logic            rx_err;
  logic            rx_sd_busy;
  logic [N_CH-1:0] repeat_reqs;
  logic [N_CH-1:0] toggle_com_src_reqs;
  logic [N_CH-1:0] replies_ok;
  logic [N_CH-1:0] replies_reception;

  modport master (
    output delays_after_cmds_for_reply, rx_start_bit_accepted, rx_frame_end,
           rx_err, rx_sd_busy,
    input  repeat_reqs, toggle_com_src_reqs, replies_ok, replies_reception
  );

  modport slave (
    input  delays_after_cmds_for_reply, rx_start_bit_accepted, rx_frame_end,
           rx_err, rx_sd_busy,
    output repeat_reqs, toggle_com_src_reqs, replies_ok, replies_reception
  );
endinterface

// File: rtl/reply_supervisor.sv
// Per-channel reply supervisor: reply window tracking, frame watchdog, retry/toggle escalation.
// Optional per-channel FAIL statistics enabled by defining REPLY_SUPERVISOR_STATS_EN.
module reply_supervisor #(
  parameter int N_CH          = 3,
  parameter int MAX_REPEATS   = 2,
  parameter int FRAME_TIMEOUT = 1024,
  parameter int TMO_W         = 11
) (
  input  logic                clk,
  input  logic                n_rst,
  reply_supervisor_if.slave   bus
`ifdef REPLY_SUPERVISOR_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [8*N_CH-1:0]   fail_counts
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RECV} state_t;

  logic fe_q;
  logic fe_fall;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) fe_q <= 1'b0;
    else        fe_q <= bus.rx_frame_end;
  end

  assign fe_fall = !bus.rx_frame_end && fe_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state;
    logic             win_q;
    logic [3:0]       retry;
    logic [TMO_W-1:0] tmo;
    logic             rep_q, tog_q, ok_q, rx_q;
    logic             win, win_rise, win_fall;
    logic             fail, ok;

    assign win      = bus.delays_after_cmds_for_reply[i];
    assign win_rise = win && !win_q;
    assign win_fall = !win && win_q;

    // An rx_err always ends the frame immediately, so an error coinciding with
    // the frame-end fall still takes the FAIL path.
    always_comb begin
      fail = 1'b0;
      ok   = 1'b0;
      case (state)
        WAIT:    fail = win_fall;
        RECV: begin
          fail = bus.rx_err || (tmo == TMO_W'(FRAME_TIMEOUT));
          ok   = !fail && fe_fall;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        state <= IDLE;
        win_q <= 1'b0;
        retry <= '0;
        tmo   <= '0;
        rep_q <= 1'b0;
        tog_q <= 1'b0;
        ok_q  <= 1'b0;
        rx_q  <= 1'b0;
      end else begin
        win_q <= win;
        rep_q <= 1'b0;
        tog_q <= 1'b0;
        ok_q  <= 1'b0;
        case (state)
          IDLE: if (win_rise) state <= WAIT;
          WAIT: begin
            if (win_fall) begin
              state <= IDLE;
            end else if (win && bus.rx_start_bit_accepted) begin
              state <= RECV;
              rx_q  <= 1'b1;
              tmo   <= '0;
            end
          end
          RECV: begin
            // A window re-rising while the reply closes opens a fresh wait.
            if (fail || ok) begin
              state <= win_rise ? WAIT : IDLE;
              rx_q  <= 1'b0;
            end else if ((bus.rx_sd_busy || !bus.rx_frame_end) && (tmo != '1)) begin
              tmo <= tmo + TMO_W'(1);
            end
          end
          default: state <= IDLE;
        endcase

        if (ok) begin
          ok_q  <= 1'b1;
          retry <= '0;
        end else if (fail) begin
          if (retry < 4'(MAX_REPEATS)) begin
            rep_q <= 1'b1;
            retry <= retry + 4'd1;
          end else begin
            tog_q <= 1'b1;
            retry <= '0;
          end
        end
      end
    end

    assign bus.repeat_reqs[i]         = rep_q;
    assign bus.toggle_com_src_reqs[i] = tog_q;
    assign bus.replies_ok[i]          = ok_q;
    assign bus.replies_reception[i]   = rx_q;

`ifdef REPLY_SUPERVISOR_STATS_EN
    logic [7:0] fcnt;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                     fcnt <= '0;
      else if (stats_clr)             fcnt <= '0;
      else if (fail && fcnt != '1)    fcnt <= fcnt + 8'd1;
    end

    assign fail_counts[8*i +: 8] = fcnt;
`endif
  end

endmodule

// File: tb/tb_reply_supervisor.sv
// Directed, table-driven bench for reply_supervisor plus hand sequences for
// async reset and the frame-timeout watchdog (second instance, FRAME_TIMEOUT=16).
module tb_reply_supervisor;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  reply_supervisor_if #(.N_CH(3)) bus   ();
  reply_supervisor_if #(.N_CH(3)) bus_t ();

`ifdef REPLY_SUPERVISOR_STATS_EN
  logic        stats_clr = 1'b0;
  logic [23:0] fail_counts, fail_counts_t;
`endif

  reply_supervisor #(.N_CH(3), .MAX_REPEATS(2), .FRAME_TIMEOUT(1024), .TMO_W(11)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
`ifdef REPLY_SUPERVISOR_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .fail_counts (fail_counts)
`endif
  );

  reply_supervisor #(.N_CH(3), .MAX_REPEATS(2), .FRAME_TIMEOUT(16), .TMO_W(5)) dut_t (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_t.slave)
`ifdef REPLY_SUPERVISOR_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .fail_counts (fail_counts_t)
`endif
  );

  typedef struct {
    logic [2:0] win;
    logic       st, fe, err, busy;
    logic [2:0] rep, tog, ok, recv;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic [2:0] win, input logic st, input logic fe,
                     input logic err, input logic busy, input logic [2:0] rep,
                     input logic [2:0] tog, input logic [2:0] ok, input logic [2:0] recv);
    vec_t v;
    v.win = win; v.st = st; v.fe = fe; v.err = err; v.busy = busy;
    v.rep = rep; v.tog = tog; v.ok = ok; v.recv = recv;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got rep/tog/ok/recv=%b/%b/%b/%b expected %b/%b/%b/%b", name,
               got[11:9], got[8:6], got[5:3], got[2:0], exp[11:9], exp[8:6], exp[5:3], exp[2:0]);
    end
  endtask

  function automatic logic [11:0] outs();
    return {bus.repeat_reqs, bus.toggle_com_src_reqs, bus.replies_ok, bus.replies_reception};
  endfunction

  task automatic drive(input logic [2:0] win, input logic st, input logic fe,
                       input logic err, input logic busy);
    bus.delays_after_cmds_for_reply = win;
    bus.rx_start_bit_accepted = st;
    bus.rx_frame_end = fe;
    bus.rx_err = err;
    bus.rx_sd_busy = busy;
  endtask

  initial begin
    int hit;
    logic recv16;
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_t.delays_after_cmds_for_reply = '0;
    bus_t.rx_start_bit_accepted = 1'b0;
    bus_t.rx_frame_end = 1'b0;
    bus_t.rx_err = 1'b0;
    bus_t.rx_sd_busy = 1'b0;

    //   win    st  fe  err busy  rep     tog     ok      recv
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b100, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b100, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b100, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b100, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    // ch0+ch2 share one start bit, window drop in RECV ignored, frame OK
    add(3'b101, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b101, 1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b101);
    add(3'b101, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b101);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b101);
    add(3'b000, 0, 1, 0, 0, 3'b000, 3'b000, 3'b000, 3'b101);
    add(3'b000, 0, 1, 0, 0, 3'b000, 3'b000, 3'b000, 3'b101);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b101, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    // ch2 retry counter cleared by OK: rep, rep, then toggle
    add(3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b100, 3'b000, 3'b000, 3'b000);
    add(3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b100, 3'b000, 3'b000, 3'b000);
    add(3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b100, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    // ch1 rx_err mid-frame, later frame end gives no OK
    add(3'b010, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b010, 1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b010);
    add(3'b010, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000, 3'b010);
    add(3'b010, 0, 0, 1, 1, 3'b010, 3'b000, 3'b000, 3'b000);
    add(3'b010, 0, 1, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    // ch0 start coinciding with window rise is not accepted; err + frame-end fall -> FAIL
    add(3'b001, 1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b001, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b001, 1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b001);
    add(3'b001, 0, 1, 0, 0, 3'b000, 3'b000, 3'b000, 3'b001);
    add(3'b001, 0, 0, 1, 0, 3'b001, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    // ch1 window re-rises in the FAIL cycle: back to WAIT, counter still advances
    add(3'b010, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b010, 1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b010);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b010);
    add(3'b010, 0, 0, 1, 0, 3'b010, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b010, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", outs(), 12'h000);
    n_rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].win, vecs[i].st, vecs[i].fe, vecs[i].err, vecs[i].busy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].rep, vecs[i].tog, vecs[i].ok, vecs[i].recv});
    end

    // ch1 retry=1 and in RECV, then async reset
    @(negedge clk); drive(3'b010, 0, 0, 0, 0);
    @(negedge clk); drive(3'b000, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("rst_pre_rep", outs(), {3'b010, 3'b000, 3'b000, 3'b000});
    @(negedge clk); drive(3'b010, 0, 0, 0, 0);
    @(negedge clk); drive(3'b010, 1, 0, 0, 0);
    @(posedge clk); #1;
    check("rst_pre_recv", outs(), {3'b000, 3'b000, 3'b000, 3'b010});
    @(negedge clk); drive(3'b010, 0, 0, 0, 0);
    #2 n_rst = 1'b0;
    #1;
    check("rst_async", outs(), 12'h000);
    @(negedge clk); n_rst = 1'b1; drive(3'b000, 0, 0, 0, 0);
    @(negedge clk); drive(3'b010, 0, 0, 0, 0);
    @(negedge clk); drive(3'b000, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("rst_retry_cleared", outs(), {3'b010, 3'b000, 3'b000, 3'b000});

    // watchdog: FRAME_TIMEOUT=16 with rx_frame_end held low
    @(negedge clk); bus_t.delays_after_cmds_for_reply = 3'b001;
    @(negedge clk); bus_t.rx_start_bit_accepted = 1'b1;
    @(posedge clk); #1;
    check("tmo_entry", {bus_t.repeat_reqs, bus_t.toggle_com_src_reqs, bus_t.replies_ok,
          bus_t.replies_reception}, {3'b000, 3'b000, 3'b000, 3'b001});
    @(negedge clk); bus_t.rx_start_bit_accepted = 1'b0;
    hit = 0;
    recv16 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 16) recv16 = bus_t.replies_reception[0];
      if (bus_t.repeat_reqs != 3'b000) begin
        hit = k;
        break;
      end
    end
    n_cmp++;
    if (hit != 17) begin
      n_bad++;
      $display("FAIL tmo_latency: repeat after %0d clocks expected 17", hit);
    end
    check("tmo_pulse", {bus_t.repeat_reqs, bus_t.toggle_com_src_reqs, bus_t.replies_ok,
          bus_t.replies_reception}, {3'b001, 3'b000, 3'b000, 3'b000});
    n_cmp++;
    if (recv16 !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_recv_held: reception at clock 16 = %b expected 1", recv16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
